// File: rtl/imm_scan_ctrl.sv
// imm_scan_ctrl: frame sequencer for the image masking datapath.
// Ports: clk/reset_n, start/hold, offsets in; pixel addr, offsets, strobes out.
module imm_scan_ctrl #(
  parameter int IMG_ROWS  = 240,
  parameter int IMG_COLS  = 320,
  parameter int MASK_ROWS = 100,
  parameter int MASK_COLS = 200,
  parameter int PIPE_LAT  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       hold,
  input  logic [7:0] row_off_in,
  input  logic [8:0] col_off_in,
  output logic [7:0] pixel_row,
  output logic [8:0] pixel_col,
  output logic [7:0] mask_row_offset,
  output logic [8:0] mask_col_offset,
  output logic       issue_valid,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] ROW_LIM  = 8'(IMG_ROWS - MASK_ROWS);
  localparam logic [8:0] COL_LIM  = 9'(IMG_COLS - MASK_COLS);
  localparam logic [7:0] ROW_LAST = 8'(IMG_ROWS - 1);
  localparam logic [8:0] COL_LAST = 9'(IMG_COLS - 1);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [PIPE_LAT-1:0] pipe;
  logic [PIPE_LAT-1:0] pipe_nxt;
  logic                last_col;
  logic                last_pix;

  assign issue_valid = (state == SCAN) && !hold;
  assign busy        = (state == SCAN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign wr_en       = pipe[PIPE_LAT-1];

  assign last_col = (pixel_col == COL_LAST);
  assign last_pix = last_col && (pixel_row == ROW_LAST);

  // Shift form avoids a negative slice when PIPE_LAT is 1.
  assign pipe_nxt = (pipe << 1) | PIPE_LAT'(issue_valid);

  // DRAIN leaves as the final result retires, so done
  // lands on the cycle right after the last wr_en.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (issue_valid && last_pix) state_nxt = DRAIN;
      DRAIN:   if (pipe_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      pipe            <= '0;
      pixel_row       <= '0;
      pixel_col       <= '0;
      mask_row_offset <= '0;
      mask_col_offset <= '0;
    end else begin
      state <= state_nxt;
      pipe  <= pipe_nxt;
      if (state == IDLE && start) begin
        mask_row_offset <= (row_off_in > ROW_LIM) ?
                           ROW_LIM : row_off_in;
        mask_col_offset <= (col_off_in > COL_LIM) ?
                           COL_LIM : col_off_in;
        pixel_row <= '0;
        pixel_col <= '0;
      end else if (issue_valid && !last_pix) begin
        if (last_col) begin
          pixel_col <= '0;
          pixel_row <= pixel_row + 8'd1;
        end else begin
          pixel_col <= pixel_col + 9'd1;
        end
      end
    end
  end

endmodule
